apb_regfile_v2: RTL
===================

Name: apb_regfile_v2

Overview:
Parametrised APB4 register file, successor to the fixed 16-bit control/status block. It provides N generic RW control registers, a hardware-status RO register, a W1C interrupt status register with an enable mask and IRQ output, a write-only command port that emits a one-cycle pulse, and a constant ID register. It adds byte strobes, programmable wait states and PSLVERR on illegal accesses, and sits on the peripheral APB segment as the control plane for one IP.

Parameters:
DATA_W, 32, register/bus width; multiple of 8, 8..32
ADDR_W, 8, PADDR width; minimum 7
NUM_RW, 4, number of generic RW registers, 1..16
WAIT_CYCLES, 0, PREADY-low cycles inserted in every access phase, 0..15
RST_VAL, 0, reset value of every RW register (DATA_W bits)
ID_VALUE, 32'hA9B0_0002, ID register contents, truncated to DATA_W

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  slave select
PENABLE  in  1  access phase
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_W  byte address
PWDATA  in  DATA_W  write data
PSTRB  in  DATA_W/8  byte write strobes
PRDATA  out  DATA_W  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error, valid only with PREADY
hw_status  in  DATA_W  live value returned by STATUS
int_event  in  DATA_W  per-bit interrupt set pulses, level-sampled each cycle
irq  out  1  registered OR of (INT_STAT & INT_EN)
cmd_valid  out  1  one-cycle pulse on accepted CMD write
cmd_data  out  DATA_W  data of last CMD write
ctrl_out  out  NUM_RW*DATA_W  flattened RW registers; reg i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Address map, byte addressed, 4-byte stride: RW[i] at 0x00+4*i; STATUS 0x40 (RO); INT_STAT 0x44 (RW1C); INT_EN 0x48 (RW); CMD 0x4C (WO); ID 0x50 (RO).
- An access is illegal if any of the following holds: PADDR[1:0]!=0; unmapped address, including RW indices >= NUM_RW; write to STATUS or ID; read of CMD.
- Wait counter: clears when PENABLE is low or PREADY is high; increments while PSEL&PENABLE&!PREADY.
- PREADY = PSEL & PENABLE & (count==WAIT_CYCLES). PREADY is 0 whenever PENABLE is low. With WAIT_CYCLES=0, the first access cycle completes.
- Commit edge is the clock edge where PSEL&PENABLE&PREADY. All register writes, W1C clears and cmd_valid take effect on that edge only, never during wait cycles.
- PSLVERR = PREADY & illegal. Illegal accesses change no state and produce no cmd_valid.
- PRDATA is registered. It is loaded on the setup-phase edge (PSEL & !PENABLE & !PWRITE) with the addressed value, or 0 if the read is illegal. It is stable through the entire access phase and holds between transfers. STATUS captures hw_status at that setup edge.
- Byte strobes:
  - RW/INT_EN: byte k is updated only when PSTRB[k]=1.
  - INT_STAT: bit b is cleared when PWDATA[b]=1 and its byte strobe is set.
  - CMD: ignores PSTRB; cmd_data <= PWDATA.
- INT_STAT next value = (INT_STAT & ~clear_mask) | int_event. If set and clear hit the same bit in the same cycle, set wins.
- irq is registered from the current INT_STAT & INT_EN, giving 1 cycle of latency after INT_STAT changes.
- cmd_valid is high exactly one cycle, the cycle after the commit edge. Back-to-back CMD writes give a separate pulse for each.
- Reset values: RW = RST_VAL; INT_STAT = 0; INT_EN = 0; PRDATA = 0; cmd_data = 0; cmd_valid = 0; irq = 0; wait counter = 0.
- Reset asserted mid-transfer: all state returns to reset values immediately and the in-flight write is discarded. After release, the master must restart with a setup phase.
- PSEL dropped mid-wait, which is a protocol violation: the counter clears and nothing commits.

Test Plan:
- Reset, then read 0x00..0x0C, 0x44, 0x48, 0x50 -> RST_VAL, 0, 0, ID_VALUE; PSLVERR=0; irq=0.
- WAIT_CYCLES=3: write 0x04 <= 0x1234_5678 -> PREADY low exactly 3 access cycles, then high 1 cycle; readback returns 0x1234_5678 with the same 3-cycle wait.
- Write 0x00 <= 0xFFFF_FFFF with PSTRB=4'b0101, prior value 0 -> reads 0x00FF_00FF; ctrl_out[31:0] matches.
- int_event bit3 pulsed with INT_EN=0x8 -> INT_STAT=0x8 and irq=1 one cycle later. Then W1C 0x8 in the same cycle as a new event on bit3 -> bit remains set. W1C 0x8 with no event -> INT_STAT=0, then irq=0.
- Write CMD <= 0xA5 twice back-to-back -> two one-cycle cmd_valid pulses with cmd_data=0xA5; a read of 0x4C returns PRDATA=0 and PSLVERR=1.
- Illegal accesses, each returning PSLVERR=1 with no state change:
  - write 0x40
  - write 0x50
  - read 0x10 with NUM_RW=4
  - access to 0x02
- Reset mid-transfer: assert PRESETn low during a wait cycle of a write to 0x08 -> after release, 0x08 reads RST_VAL.

Source files
------------

// File: rtl/apb_regfile_v2.sv
// APB4 control-plane register file: generic RW bank, live status, W1C interrupts with mask,
// write-only command pulse port and a constant ID register, with byte strobes and wait states.
module apb_regfile_v2 #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       NUM_RW      = 4,
    parameter int unsigned       WAIT_CYCLES = 0,
    parameter logic [DATA_W-1:0] RST_VAL     = '0,
    parameter logic [31:0]       ID_VALUE    = 32'hA9B0_0002
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [ADDR_W-1:0]        PADDR,
    input  logic [DATA_W-1:0]        PWDATA,
    input  logic [DATA_W/8-1:0]      PSTRB,
    output logic [DATA_W-1:0]        PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    input  logic [DATA_W-1:0]        hw_status,
    input  logic [DATA_W-1:0]        int_event,
    output logic                     irq,
    output logic                     cmd_valid,
    output logic [DATA_W-1:0]        cmd_data,
    output logic [NUM_RW*DATA_W-1:0] ctrl_out
);

    localparam int unsigned       STRB_W   = DATA_W / 8;
    localparam logic [4:0]        NUM_RW_L = 5'(NUM_RW);
    localparam logic [3:0]        WAIT_L   = 4'(WAIT_CYCLES);
    localparam logic [DATA_W-1:0] ID_L     = ID_VALUE[DATA_W-1:0];

    logic [3:0]        cnt_q, cnt_d;
    logic              access, ready;
    logic [4:0]        word;
    logic              hi_zero;
    logic              sel_rw, sel_status, sel_int_stat, sel_int_en, sel_cmd, sel_id;
    logic              illegal, commit_wr;
    logic [DATA_W-1:0] wmask, rdata;
    logic [DATA_W-1:0] rw_q [NUM_RW];
    logic [DATA_W-1:0] rw_d [NUM_RW];
    logic [DATA_W-1:0] int_stat_q, int_stat_d, int_en_q, int_en_d, clr_mask;
    logic [DATA_W-1:0] prdata_q, prdata_d, cmd_data_q, cmd_data_d;
    logic              cmd_valid_q, cmd_valid_d, irq_q, irq_d;

    assign access = PSEL & PENABLE;
    assign ready  = access & (cnt_q == WAIT_L);

    // Counter only runs during an uncompleted access phase; anything else restarts it.
    always_comb begin
        cnt_d = (!access || ready) ? 4'd0 : cnt_q + 4'd1;
    end

    assign word         = PADDR[6:2];
    assign hi_zero      = (PADDR >> 7) == '0;
    assign sel_rw       = hi_zero & ~word[4] & ({1'b0, word[3:0]} < NUM_RW_L);
    assign sel_status   = hi_zero & (word == 5'h10);
    assign sel_int_stat = hi_zero & (word == 5'h11);
    assign sel_int_en   = hi_zero & (word == 5'h12);
    assign sel_cmd      = hi_zero & (word == 5'h13);
    assign sel_id       = hi_zero & (word == 5'h14);

    assign illegal = (PADDR[1:0] != 2'b00)
                   | ~(sel_rw | sel_status | sel_int_stat | sel_int_en | sel_cmd | sel_id)
                   | (PWRITE & (sel_status | sel_id))
                   | (~PWRITE & sel_cmd);
    assign commit_wr = ready & ~illegal & PWRITE;

    always_comb begin
        wmask = '0;
        for (int unsigned k = 0; k < STRB_W; k++) begin
            wmask[k*8 +: 8] = {8{PSTRB[k]}};
        end
    end

    always_comb begin
        rdata = '0;
        if (sel_rw) begin
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                if (word[3:0] == 4'(i)) rdata = rw_q[i];
            end
        end
        if (sel_status)   rdata = hw_status;
        if (sel_int_stat) rdata = int_stat_q;
        if (sel_int_en)   rdata = int_en_q;
        if (sel_id)       rdata = ID_L;
        if (illegal)      rdata = '0;
    end

    always_comb begin
        prdata_d = prdata_q;
        if (PSEL && !PENABLE && !PWRITE) prdata_d = rdata;
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_RW; i++) begin
            rw_d[i] = rw_q[i];
            if (commit_wr && sel_rw && (word[3:0] == 4'(i))) begin
                rw_d[i] = (rw_q[i] & ~wmask) | (PWDATA & wmask);
            end
        end
    end

    always_comb begin
        clr_mask   = (commit_wr && sel_int_stat) ? (PWDATA & wmask) : '0;
        // New events are ORed after the clear so a coincident set survives.
        int_stat_d = (int_stat_q & ~clr_mask) | int_event;
        int_en_d   = int_en_q;
        if (commit_wr && sel_int_en) int_en_d = (int_en_q & ~wmask) | (PWDATA & wmask);
        cmd_valid_d = commit_wr & sel_cmd;
        cmd_data_d  = cmd_valid_d ? PWDATA : cmd_data_q;
        irq_d       = |(int_stat_q & int_en_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q       <= '0;
            int_stat_q  <= '0;
            int_en_q    <= '0;
            prdata_q    <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            irq_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_RW; i++) rw_q[i] <= RST_VAL;
        end else begin
            cnt_q       <= cnt_d;
            int_stat_q  <= int_stat_d;
            int_en_q    <= int_en_d;
            prdata_q    <= prdata_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            irq_q       <= irq_d;
            for (int unsigned i = 0; i < NUM_RW; i++) rw_q[i] <= rw_d[i];
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
        assign ctrl_out[g*DATA_W +: DATA_W] = rw_q[g];
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = ready;
    assign PSLVERR   = ready & illegal;
    assign irq       = irq_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;

endmodule
